// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-format types and helpers for the immediate extension arbiter.
package imm_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4
  } imm_fmt_e;
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;
  function automatic logic is_legal_fmt(input logic [2:0] fmt);
    return fmt <= 3'd4;
  endfunction
endpackage

// File: rtl/imm_format_decode.sv
// imm_format_decode: combinational immediate reconstruction and sign extension for I/S/B/U/J formats.
module imm_format_decode
  import imm_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [2:0]  fmt_i,
  output logic [31:0] imm_o,
  output logic        err_o
);
  assign err_o = !is_legal_fmt(fmt_i);
  always_comb begin
    imm_o = (fmt_i == FMT_I) ? {{20{instr_i[31]}}, instr_i[31:20]} :
            (fmt_i == FMT_S) ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
            (fmt_i == FMT_B) ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
            (fmt_i == FMT_U) ? {instr_i[31:12], 12'b0} :
            (fmt_i == FMT_J) ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
            32'h0;
  end
endmodule

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin arbiter sharing one immediate extension unit,
// returning results through a single registered valid/ready slot.
module imm_ext_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = imm_pkg::XLEN,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_instr,
  input  logic [NUM_REQ*3-1:0]  req_fmt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_imm,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err
);
  imm_pkg::slot_state_e state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [XLEN-1:0]      imm_q, imm_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 err_q, err_d;
  logic [2*NUM_REQ-1:0] rot;
  logic [IDW-1:0]       off, gnt_id;
  logic [IDW:0]         sum;
  logic                 any_req, slot_free, xfer;
  logic [31:0]          dec_instr;
  logic [2:0]           dec_fmt;
  logic [31:0]          dec_imm;
  logic                 dec_err;
  // Rotate the request vector so the search starts at rr_ptr; the lowest set bit wins.
  always_comb begin
    rot = {req_valid, req_valid} >> rr_ptr_q;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IDW'(i);
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    gnt_id = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : sum[IDW-1:0];
  end
  assign any_req   = |req_valid;
  assign slot_free = (state_q == imm_pkg::ST_EMPTY) || rsp_ready;
  assign xfer      = any_req && slot_free && !rst;
  assign req_ready = xfer ? (NUM_REQ'(1) << gnt_id) : '0;
  always_comb begin
    dec_instr = req_instr[31:0];
    dec_fmt   = req_fmt[2:0];
    for (int i = 1; i < NUM_REQ; i++)
      if (gnt_id == IDW'(i)) begin
        dec_instr = req_instr[i*32 +: 32];
        dec_fmt   = req_fmt[i*3 +: 3];
      end
  end
  imm_format_decode u_dec (
    .instr_i (dec_instr),
    .fmt_i   (dec_fmt),
    .imm_o   (dec_imm),
    .err_o   (dec_err)
  );
  always_comb begin
    state_d  = xfer ? imm_pkg::ST_FULL : (rsp_ready ? imm_pkg::ST_EMPTY : state_q);
    rr_ptr_d = !xfer ? rr_ptr_q : (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    imm_d    = xfer ? XLEN'(dec_imm) : imm_q;
    id_d     = xfer ? gnt_id : id_q;
    err_d    = xfer ? dec_err : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= imm_pkg::ST_EMPTY;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q <= '0;
      id_q  <= '0;
      err_q <= 1'b0;
    end else begin
      imm_q <= imm_d;
      id_q  <= id_d;
      err_q <= err_d;
    end
  end
  assign rsp_valid = (state_q == imm_pkg::ST_FULL);
  assign rsp_imm   = imm_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
endmodule
